// File: rtl/sobel_pkg.sv
// Shared types, defaults and slot arithmetic for the sobel frame controller.
package sobel_pkg;

    localparam int DEF_IMG_W    = 352;
    localparam int DEF_IMG_H    = 288;
    localparam int DEF_ADDR_W   = 16;
    localparam int DEF_OUT_BASE = DEF_IMG_W * DEF_IMG_H / 4;

    typedef logic [7:0]  pix_t;
    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ZERO_TOP,
        S_LOAD,
        S_COMPUTE,
        S_ZERO_BOT,
        S_DONE
    } ctrl_state_t;

    // Line-buffer slot index addition modulo 3 (slot values are 0..2).
    function automatic logic [1:0] slot_add(input logic [1:0] s, input logic [1:0] n);
        logic [2:0] t;
        t = {1'b0, s} + {1'b0, n};
        if (t >= 3'd3)
            t = t - 3'd3;
        return t[1:0];
    endfunction

endpackage

// File: rtl/sobel.sv
// Combinational 3x3 sobel magnitude with >>3 scaling, saturation and noise threshold.
module sobel
    import sobel_pkg::*;
(
    input  pix_t s11,
    input  pix_t s12,
    input  pix_t s13,
    input  pix_t s21,
    input  pix_t s22,
    input  pix_t s23,
    input  pix_t s31,
    input  pix_t s32,
    input  pix_t s33,
    output pix_t mag
);

    logic signed [11:0] gx;
    logic signed [11:0] gy;
    logic [11:0]        ax;
    logic [11:0]        ay;
    logic [12:0]        sum;
    logic [9:0]         scaled;

    function automatic logic signed [11:0] ext(input pix_t p);
        return $signed({4'b0000, p});
    endfunction

    // Gradients, absolute sum, scale, saturate and threshold.
    always_comb begin
        gx = ext(s13) - ext(s11) + ((ext(s23) - ext(s21)) <<< 1) + ext(s33) - ext(s31);
        gy = ext(s11) - ext(s31) + ((ext(s12) - ext(s32)) <<< 1) + ext(s13) - ext(s33);
        ax = gx[11] ? $unsigned(-gx) : $unsigned(gx);
        ay = gy[11] ? $unsigned(-gy) : $unsigned(gy);
        sum = {1'b0, ax} + {1'b0, ay};
        scaled = sum[12:3];
        mag = (scaled > 10'd255) ? 8'hFF : scaled[7:0];
        if (scaled <= 10'd20)
            mag = '0;
    end

    // s22 does not contribute to either gradient.
    logic unused_centre;
    always_comb unused_centre = ^s22;

endmodule

// File: rtl/sobel_line_buffer.sv
// Three-row pixel buffer: one 32-bit word write port, combinational 6-pixel span read.
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int KW    = $clog2(IMG_W / 4)
)
(
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [1:0]           wr_slot,
    input  logic [KW-1:0]        wr_word,
    input  word_t                wr_data,
    input  logic [KW-1:0]        rd_word,
    output logic [2:0][5:0][7:0] span
);

    localparam int XW = $clog2(IMG_W);

    pix_t mem [3][IMG_W];

    // Store the four pixels of one input word into the selected row slot.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < 4; i++)
                mem[wr_slot][XW'(4 * int'(wr_word) + int'(i))] <= wr_data[8*i +: 8];
        end
    end

    // Pixels x=4k-1..4k+4 of every slot; positions outside the row read as 0.
    always_comb begin
        span = '0;
        for (int unsigned s = 0; s < 3; s++) begin
            for (int unsigned j = 0; j < 6; j++) begin
                int x;
                x = 4 * int'(rd_word) + int'(j) - 1;
                if (x >= 0 && x < IMG_W)
                    span[s][j] = mem[2'(s)][XW'(x)];
            end
        end
    end

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame controller: zero border rows, stream input rows into the line buffer,
// compute four sobel lanes per output word and raise finish at the end.
module sobel_frame_ctrl
    import sobel_pkg::*;
#(
    parameter int IMG_W    = DEF_IMG_W,
    parameter int IMG_H    = DEF_IMG_H,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int OUT_BASE = DEF_OUT_BASE
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              finish,
    output logic              en,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [31:0]       dataW,
    input  logic [31:0]       dataR
);

    localparam int W4 = IMG_W / 4;
    localparam int KW = $clog2(W4);
    localparam int RW = $clog2(IMG_H + 1);
    localparam logic [ADDR_W-1:0] W4_A  = ADDR_W'(W4);
    localparam logic [ADDR_W-1:0] OUT_A = ADDR_W'(OUT_BASE);
    localparam logic [ADDR_W-1:0] BOT_A = ADDR_W'(OUT_BASE + (IMG_H - 1) * W4);

    ctrl_state_t state, next;

    logic [KW-1:0] k;
    logic [RW-1:0] row;
    logic [RW-1:0] ld_row;
    logic [RW-1:0] ld_last;
    logic [1:0]    ld_slot;
    logic [1:0]    top_slot;
    logic          issue_done;
    logic          pend;
    logic [1:0]    pend_slot;
    logic [KW-1:0] pend_k;
    logic          k_last;

    logic [2:0][5:0][7:0] span;
    logic [1:0]           sel_top, sel_mid, sel_bot;
    pix_t                 lane_mag [4];
    word_t                lanes;

    assign k_last = (k == KW'(W4 - 1));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= next;
    end

    // Next state and memory-port outputs.
    always_comb begin
        next   = state;
        en     = 1'b0;
        we     = 1'b0;
        addr   = '0;
        dataW  = '0;
        finish = 1'b0;
        case (state)
            S_IDLE: begin
                if (start)
                    next = S_ZERO_TOP;
            end
            S_ZERO_TOP: begin
                en   = 1'b1;
                we   = 1'b1;
                addr = OUT_A + ADDR_W'(k);
                if (k_last)
                    next = S_LOAD;
            end
            S_LOAD: begin
                // After the last issue, one tail cycle captures the final word.
                if (!issue_done) begin
                    en   = 1'b1;
                    addr = ADDR_W'(ld_row) * W4_A + ADDR_W'(k);
                end else begin
                    next = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                en    = 1'b1;
                we    = 1'b1;
                addr  = OUT_A + ADDR_W'(row) * W4_A + ADDR_W'(k);
                dataW = lanes;
                if (k_last)
                    next = (row == RW'(IMG_H - 2)) ? S_ZERO_BOT : S_LOAD;
            end
            S_ZERO_BOT: begin
                en   = 1'b1;
                we   = 1'b1;
                addr = BOT_A + ADDR_W'(k);
                if (k_last)
                    next = S_DONE;
            end
            S_DONE: begin
                finish = 1'b1;
                if (!start)
                    next = S_IDLE;
            end
            default: next = S_IDLE;
        endcase
    end

    // Word, row and slot counters plus the read-capture pipeline.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k          <= '0;
            row        <= '0;
            ld_row     <= '0;
            ld_last    <= '0;
            ld_slot    <= '0;
            top_slot   <= '0;
            issue_done <= 1'b0;
            pend       <= 1'b0;
            pend_slot  <= '0;
            pend_k     <= '0;
        end else begin
            pend      <= (state == S_LOAD) && !issue_done;
            pend_slot <= ld_slot;
            pend_k    <= k;

            if ((state == S_ZERO_TOP) || (state == S_ZERO_BOT) || (state == S_COMPUTE) ||
                ((state == S_LOAD) && !issue_done))
                k <= k_last ? '0 : k + 1'b1;

            if ((state == S_IDLE) && start) begin
                ld_row     <= '0;
                ld_slot    <= '0;
                ld_last    <= RW'(2);
                issue_done <= 1'b0;
                row        <= RW'(1);
                top_slot   <= '0;
            end

            if ((state == S_LOAD) && !issue_done && k_last) begin
                ld_row  <= ld_row + 1'b1;
                ld_slot <= slot_add(ld_slot, 2'd1);
                if (ld_row == ld_last)
                    issue_done <= 1'b1;
            end

            if ((state == S_LOAD) && issue_done)
                issue_done <= 1'b0;

            // The next LOAD fetches exactly the row following the last one fetched.
            if ((state == S_COMPUTE) && k_last) begin
                row      <= row + 1'b1;
                top_slot <= slot_add(top_slot, 2'd1);
                ld_last  <= ld_row;
            end
        end
    end

    sobel_line_buffer #(
        .IMG_W (IMG_W),
        .KW    (KW)
    ) u_line_buffer (
        .clk     (clk),
        .wr_en   (pend),
        .wr_slot (pend_slot),
        .wr_word (pend_k),
        .wr_data (dataR),
        .rd_word (k),
        .span    (span)
    );

    // Map window rows r-1, r, r+1 onto the rotating physical slots.
    always_comb begin
        sel_top = top_slot;
        sel_mid = slot_add(top_slot, 2'd1);
        sel_bot = slot_add(top_slot, 2'd2);
    end

    for (genvar i = 0; i < 4; i++) begin : g_lane
        sobel u_sobel (
            .s11 (span[sel_top][i]),
            .s12 (span[sel_top][i+1]),
            .s13 (span[sel_top][i+2]),
            .s21 (span[sel_mid][i]),
            .s22 (span[sel_mid][i+1]),
            .s23 (span[sel_mid][i+2]),
            .s31 (span[sel_bot][i]),
            .s32 (span[sel_bot][i+1]),
            .s33 (span[sel_bot][i+2]),
            .mag (lane_mag[i])
        );
    end

    // Pack lanes into the output word, forcing the column borders to 0.
    always_comb begin
        lanes = '0;
        for (int unsigned i = 0; i < 4; i++)
            lanes[8*i +: 8] = lane_mag[i];
        if (k == '0)
            lanes[7:0] = '0;
        if (k_last)
            lanes[31:24] = '0;
    end

endmodule
